io_timer_bank: RTL

Parametrised bank of independent down-counting timers on the j1 IO bus, generalising the single 32-bit periodic millis timer: N channels, configurable counter width, periodic or one-shot mode, per-channel interrupt enable, and a shared write-1-to-clear pending register. It sits in `top` beside the other IO peripherals. It drives a slice of the ORed `io_din` read bus and produces the single `interrupt_request` line into the j1.

---
 rtl/io_timer_bank_pkg.sv | 14 +
 rtl/io_timer_channel.sv | 101 ++++++++++
 rtl/io_timer_bank.sv | 74 +++++++
 3 files changed

// File: rtl/io_timer_bank_pkg.sv
// rtl/io_timer_bank_pkg.sv - register map constants shared by the timer bank and its channels
package io_timer_bank_pkg;
   localparam logic [2:0] OFS_RLD_L = 3'd0;
   localparam logic [2:0] OFS_RLD_H = 3'd1;
   localparam logic [2:0] OFS_CTRL  = 3'd2;
   localparam logic [2:0] OFS_CNT_L = 3'd3;
   localparam logic [2:0] OFS_CNT_H = 3'd4;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_IE      = 2;

   localparam int CH_STRIDE = 8;
endpackage

// File: rtl/io_timer_channel.sv
// rtl/io_timer_channel.sv - one down-counting timer channel with reload, control and CNT_H shadow
module io_timer_channel
   import io_timer_bank_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        sel_i,
   input  logic        wr_i,
   input  logic        rd_i,
   input  logic [2:0]  ofs_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   output logic        expire_o,
   output logic        ie_o
);
   localparam int HW = CNT_W - 16;

   logic [CNT_W-1:0] reload_q, reload_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [HW-1:0]    shadow_q, shadow_d;
   logic             en_q, en_d;
   logic             os_q, os_d;
   logic             ie_q, ie_d;
   logic             wr_sel;

   assign wr_sel = sel_i & wr_i;
   assign ie_o   = ie_q;

   always_comb begin
      reload_d = reload_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      en_d     = en_q;
      os_d     = os_q;
      ie_d     = ie_q;
      expire_o = en_q && (cnt_q == '0);

      if (en_q) begin
         if (cnt_q == '0) begin
            if (os_q) en_d = 1'b0;
            else      cnt_d = reload_q;
         end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end

      // Register writes come after counting so a write in the expiry cycle wins.
      if (wr_sel) begin
         case (ofs_i)
            OFS_RLD_L: reload_d[15:0] = wdata_i;
            OFS_RLD_H: begin
               reload_d[CNT_W-1:16] = wdata_i[HW-1:0];
               cnt_d                = {wdata_i[HW-1:0], reload_q[15:0]};
            end
            OFS_CTRL: begin
               if (!en_q && wdata_i[CTRL_EN]) cnt_d = reload_q;
               en_d = wdata_i[CTRL_EN];
               os_d = wdata_i[CTRL_ONESHOT];
               ie_d = wdata_i[CTRL_IE];
            end
            default: ;
         endcase
      end

      if (sel_i && rd_i && (ofs_i == OFS_CNT_L)) shadow_d = cnt_q[CNT_W-1:16];
   end

   always_comb begin
      rdata_o = 16'h0000;
      if (sel_i) begin
         case (ofs_i)
            OFS_RLD_L: rdata_o = reload_q[15:0];
            OFS_RLD_H: rdata_o = 16'(reload_q[CNT_W-1:16]);
            OFS_CTRL:  rdata_o = {13'd0, ie_q, os_q, en_q};
            OFS_CNT_L: rdata_o = cnt_q[15:0];
            OFS_CNT_H: rdata_o = 16'(shadow_q);
            default:   rdata_o = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         reload_q <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         en_q     <= 1'b0;
         os_q     <= 1'b0;
         ie_q     <= 1'b0;
      end else begin
         reload_q <= reload_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         en_q     <= en_d;
         os_q     <= os_d;
         ie_q     <= ie_d;
      end
   end
endmodule

// File: rtl/io_timer_bank.sv
// rtl/io_timer_bank.sv - bank of timer channels with shared write-1-to-clear pending and irq
module io_timer_bank
   import io_timer_bank_pkg::*;
#(
   parameter int          CHANNELS  = 4,
   parameter int          CNT_W     = 32,
   parameter logic [15:0] BASE_ADDR = 16'd120
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [15:0] mem_addr,
   input  logic [15:0] dout,
   output logic [15:0] io_din,
   output logic        irq
);
   localparam logic [15:0] PEND_OFS = 16'(CH_STRIDE * CHANNELS);

   logic [15:0]         off;
   logic                pend_sel;
   logic [CHANNELS-1:0] ch_sel;
   logic [CHANNELS-1:0] expire;
   logic [CHANNELS-1:0] ie;
   logic [15:0]         ch_rdata [CHANNELS];
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic                irq_q;

   // Addresses below BASE_ADDR wrap to large offsets and decode as nothing.
   assign off      = mem_addr - BASE_ADDR;
   assign pend_sel = (off == PEND_OFS);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign ch_sel[i] = (off[15:3] == 13'(i));

      io_timer_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk      (clk),
         .resetq   (resetq),
         .sel_i    (ch_sel[i]),
         .wr_i     (io_wr),
         .rd_i     (io_rd),
         .ofs_i    (off[2:0]),
         .wdata_i  (dout),
         .rdata_o  (ch_rdata[i]),
         .expire_o (expire[i]),
         .ie_o     (ie[i])
      );
   end

   always_comb begin
      pend_d = pend_q;
      if (pend_sel && io_wr) pend_d = pend_q & ~dout[CHANNELS-1:0];
      pend_d = pend_d | expire;
   end

   always_comb begin
      io_din = pend_sel ? 16'(pend_q) : 16'h0000;
      for (int i = 0; i < CHANNELS; i++) io_din = io_din | ch_rdata[i];
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         pend_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         irq_q  <= |(pend_q & ie);
      end
   end

   assign irq = irq_q;
endmodule
